echo_capture_ctrl: RTL

ECHO_CAPTURE_CTRL -- requirements
Module: echo_capture_ctrl

---
 rtl/echo_capture_ctrl_pkg.sv | 25 ++
 rtl/echo_capture_ctrl_rate_div.sv | 50 +++++
 rtl/echo_capture_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/echo_capture_ctrl_pkg.sv
// Shared definitions for the echo capture controller: data widths,
// default timing/frame constants, FSM state codes and the FIFO word helper.
// Optional feature macro used by the top: ECHO_CAPTURE_TAG_EN.
package echo_capture_ctrl_pkg;

    localparam int DATA_W         = 16;
    localparam int CNT_W          = 15;

    localparam int DEF_SAMPLE_DIV = 64;
    localparam int DEF_ENA_CYCLES = 48;
    localparam int DEF_FRAME_LEN  = 16384;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CAPTURE = 2'd1;
    localparam state_t ST_HALT    = 2'd2;

    // The ADC returns one redundant LSB; the stored word is the raw value
    // shifted down by one, which also frees bit 15 for the optional marker.
    function automatic logic [DATA_W-1:0] fifo_word(input logic [DATA_W-1:0] raw);
        return raw >> 1;
    endfunction

endpackage

// File: rtl/echo_capture_ctrl_rate_div.sv
// Sample-period divider for the echo capture controller: counts
// 0..SAMPLE_DIV-1 while capturing and drives a registered ADC enable that is
// high for the first ENA_CYCLES counts of every period.
module capture_rate_div
    import echo_capture_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int ENA_CYCLES = DEF_ENA_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run_next,
    input  logic restart,
    output logic ena
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             ena_q;
    logic             ena_d;

    // Next divider value: restart at 0 on frame start, wrap at period end, park at 0 when not capturing
    always_comb begin
        div_d = '0;
        if (run_next && !restart) begin
            if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        ena_d = run_next && (div_d < DIV_W'(ENA_CYCLES));
    end

    // Divider and enable registers, enable computed from the next count so it lines up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            ena_q <= 1'b0;
        end else begin
            div_q <= div_d;
            ena_q <= ena_d;
        end
    end

    assign ena = ena_q;

endmodule

// File: rtl/echo_capture_ctrl.sv
// Echo capture controller: paces an SPI ADC at a fixed sample rate after an
// ARM pulse, forwards each converted word to a FIFO, counts a frame of
// FRAME_LEN samples and halts with a sticky OVERRUN flag if the FIFO fills.
// Optional macro ECHO_CAPTURE_TAG_EN marks the first word of each frame
// by setting bit 15.
module echo_capture_ctrl
    import echo_capture_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int ENA_CYCLES = DEF_ENA_CYCLES,
    parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic              ON,
    input  logic              ARM,
    output logic              ADC_ENA,
    input  logic              ADC_FIN,
    input  logic [DATA_W-1:0] ADC_DATA,
    output logic              FIFO_WR,
    output logic [DATA_W-1:0] FIFO_DATA,
    input  logic              FIFO_FULL,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERRUN,
    output logic [CNT_W-1:0]  SAMPLE_CNT
);

    state_t            state_q;
    state_t            state_d;
    logic              fin_prev_q;
    logic              full_prev_q;
    logic              fifo_wr_q;
    logic              fifo_wr_d;
    logic [DATA_W-1:0] fifo_data_q;
    logic [DATA_W-1:0] fifo_data_d;
    logic              done_q;
    logic              done_d;
    logic              overrun_q;
    logic              overrun_d;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic [CNT_W-1:0]  sample_cnt_d;

    logic              fin_rise;
    logic              full_rise;
    logic              start;
    logic              run_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] word;

    // Frame FSM: ON low always wins; a FIN rise either stores a word or, with the FIFO full, halts
    always_comb begin
        state_d      = state_q;
        fifo_wr_d    = 1'b0;
        fifo_data_d  = fifo_data_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        sample_cnt_d = sample_cnt_q;
        start        = 1'b0;
        fin_rise     = ADC_FIN & ~fin_prev_q;
        full_rise    = FIFO_FULL & ~full_prev_q;
        cnt_inc      = sample_cnt_q + CNT_W'(1);
        word         = fifo_word(ADC_DATA);
`ifdef ECHO_CAPTURE_TAG_EN
        if (sample_cnt_q == '0) begin
            word[DATA_W-1] = 1'b1;
        end
`endif
        if (!ON) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ARM && !FIFO_FULL) begin
                        state_d      = ST_CAPTURE;
                        sample_cnt_d = '0;
                        overrun_d    = 1'b0;
                        start        = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (fin_rise && !FIFO_FULL) begin
                        fifo_wr_d    = 1'b1;
                        fifo_data_d  = word;
                        sample_cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(FRAME_LEN)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (FIFO_FULL && (fin_rise || full_rise)) begin
                        state_d   = ST_HALT;
                        overrun_d = 1'b1;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        run_next = (state_d == ST_CAPTURE);
    end

    // Control and data registers; the edge detectors track their inputs in every state
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            fin_prev_q   <= 1'b0;
            full_prev_q  <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            fin_prev_q   <= ADC_FIN;
            full_prev_q  <= FIFO_FULL;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    capture_rate_div #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .ENA_CYCLES (ENA_CYCLES)
    ) u_rate_div (
        .clk      (SYS_CLK),
        .rst      (RST),
        .run_next (run_next),
        .restart  (start),
        .ena      (ADC_ENA)
    );

    assign FIFO_WR    = fifo_wr_q;
    assign FIFO_DATA  = fifo_data_q;
    assign BUSY       = (state_q == ST_CAPTURE);
    assign DONE       = done_q;
    assign OVERRUN    = overrun_q;
    assign SAMPLE_CNT = sample_cnt_q;

endmodule
